bats_feed_arbiter: RTL and testbench

BATS_FEED_ARBITER -- requirements
Module: bats_feed_arbiter

---
 rtl/bats_pkg.sv | 27 ++
 rtl/bats_beat_reg.sv | 29 ++
 rtl/bats_feed_arbiter.sv | 136 +++++++++++++
 tb/tb_bats_feed_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bats_pkg.sv
// Shared types and defaults for the BATS feed arbiter.
// Holds the FSM encoding, the beat record and the parameter defaults.
package bats_pkg;

    localparam int MAX_BEATS_DEF  = 192;
    localparam int RESET_HOLD_DEF = 5;

    typedef enum logic [2:0] {
        RST_PULSE,
        RST_WAIT,
        IDLE,
        GRANT0,
        GRANT1,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [63:0] bytes;
        logic [7:0]  enables;
        logic        last;
    } beat_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/bats_beat_reg.sv
// Output register stage toward the parser input.
// A loaded beat stays put with valid high until the parser takes it.
module bats_beat_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [63:0] bytes,
    input  logic [7:0]  enables,
    input  logic        m_ready,
    output logic [63:0] m_bytes,
    output logic [7:0]  m_byte_enables,
    output logic        m_data_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bytes        <= '0;
            m_byte_enables <= '0;
            m_data_valid   <= 1'b0;
        end else if (load) begin
            m_bytes        <= bytes;
            m_byte_enables <= enables;
            m_data_valid   <= 1'b1;
        end else if (m_ready) begin
            m_data_valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/bats_feed_arbiter.sv
// Two-source payload arbiter feeding the UDP parser input.
// Round-robin at payload boundaries, overlong payloads are drained and reset the parser.
module bats_feed_arbiter
    import bats_pkg::*;
#(
    parameter int MAX_BEATS  = MAX_BEATS_DEF,
    parameter int RESET_HOLD = RESET_HOLD_DEF
) (
    input  logic        Clk40,
    input  logic        reset,
    input  logic [63:0] s0_bytes,
    input  logic [7:0]  s0_byte_enables,
    input  logic        s0_valid,
    input  logic        s0_last,
    output logic        s0_ready,
    input  logic [63:0] s1_bytes,
    input  logic [7:0]  s1_byte_enables,
    input  logic        s1_valid,
    input  logic        s1_last,
    output logic        s1_ready,
    output logic [63:0] m_bytes,
    output logic [7:0]  m_byte_enables,
    output logic        m_data_valid,
    input  logic        m_ready,
    output logic        parser_reset,
    output logic [31:0] pkt_count0,
    output logic [31:0] pkt_count1,
    output logic [15:0] abort_count
);

    localparam logic [7:0] BEAT_LIMIT = 8'(MAX_BEATS);
    localparam logic [7:0] HOLD_LAST  =
        (RESET_HOLD > 1) ? 8'(RESET_HOLD - 1) : 8'd0;

    state_t     state;
    logic       cur_src;
    logic       last_grant;
    logic [7:0] beat_cnt;
    logic [7:0] hold_cnt;

    beat_t      beat;
    logic       src_valid;
    logic       granted;
    logic       port_ready;
    logic       accept;
    logic       overrun;
    logic       load;

    assign beat = cur_src ? {s1_bytes, s1_byte_enables, s1_last}
                          : {s0_bytes, s0_byte_enables, s0_last};
    assign src_valid = cur_src ? s1_valid : s0_valid;

    assign granted    = (state == GRANT0) || (state == GRANT1);
    // While draining, the aborted source is swallowed regardless of the parser.
    assign port_ready = (state == DRAIN) ||
                        (granted && (!m_data_valid || m_ready));
    assign s0_ready   = port_ready && !cur_src;
    assign s1_ready   = port_ready && cur_src;

    assign accept  = port_ready && src_valid;
    assign overrun = granted && accept && !beat.last &&
                     (beat_cnt == BEAT_LIMIT);
    assign load    = granted && accept && !overrun &&
                     (beat.enables != 8'd0);

    bats_beat_reg u_beat_reg (
        .clk            (Clk40),
        .rst            (reset),
        .load           (load),
        .bytes          (beat.bytes),
        .enables        (beat.enables),
        .m_ready        (m_ready),
        .m_bytes        (m_bytes),
        .m_byte_enables (m_byte_enables),
        .m_data_valid   (m_data_valid)
    );

    always_ff @(posedge Clk40 or posedge reset) begin
        if (reset) begin
            state        <= RST_PULSE;
            parser_reset <= 1'b0;
            hold_cnt     <= '0;
            beat_cnt     <= '0;
            cur_src      <= 1'b0;
            last_grant   <= 1'b1;
            pkt_count0   <= '0;
            pkt_count1   <= '0;
            abort_count  <= '0;
        end else begin
            parser_reset <= 1'b0;
            case (state)
                RST_PULSE: begin
                    parser_reset <= 1'b1;
                    hold_cnt     <= '0;
                    state        <= RST_WAIT;
                end
                RST_WAIT: begin
                    if (hold_cnt >= HOLD_LAST) state <= IDLE;
                    else hold_cnt <= hold_cnt + 8'd1;
                end
                IDLE: begin
                    beat_cnt <= '0;
                    if (s0_valid && (!s1_valid || last_grant)) begin
                        cur_src    <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= GRANT0;
                    end else if (s1_valid) begin
                        cur_src    <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= GRANT1;
                    end
                end
                GRANT0, GRANT1: begin
                    if (accept) begin
                        beat_cnt <= sat_inc(beat_cnt);
                        if (overrun) begin
                            state <= DRAIN;
                        end else if (beat.last) begin
                            if (cur_src) pkt_count1 <= pkt_count1 + 32'd1;
                            else pkt_count0 <= pkt_count0 + 32'd1;
                            state <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && beat.last) begin
                        abort_count <= abort_count + 16'd1;
                        state       <= RST_PULSE;
                    end
                end
                default: state <= RST_PULSE;
            endcase
        end
    end

endmodule

// File: tb/tb_bats_feed_arbiter.sv
// Self-checking bench for bats_feed_arbiter.
// Payload-level reference model with per-source queues and a stream scoreboard.
module tb_bats_feed_arbiter;
    import bats_pkg::*;

    localparam int MAXB = 192;
    localparam int HOLD = 5;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] sb [2];
    logic [7:0]  se [2];
    logic        sv [2];
    logic        sl [2];
    logic        s0_ready, s1_ready;
    logic        m_ready;
    logic [63:0] m_bytes;
    logic [7:0]  m_byte_enables;
    logic        m_data_valid;
    logic        parser_reset;
    logic [31:0] pkt_count0, pkt_count1;
    logic [15:0] abort_count;

    always #5 clk = ~clk;

    bats_feed_arbiter #(.MAX_BEATS(MAXB), .RESET_HOLD(HOLD)) dut (
        .Clk40           (clk),
        .reset           (reset),
        .s0_bytes        (sb[0]),
        .s0_byte_enables (se[0]),
        .s0_valid        (sv[0]),
        .s0_last         (sl[0]),
        .s0_ready        (s0_ready),
        .s1_bytes        (sb[1]),
        .s1_byte_enables (se[1]),
        .s1_valid        (sv[1]),
        .s1_last         (sl[1]),
        .s1_ready        (s1_ready),
        .m_bytes         (m_bytes),
        .m_byte_enables  (m_byte_enables),
        .m_data_valid    (m_data_valid),
        .m_ready         (m_ready),
        .parser_reset    (parser_reset),
        .pkt_count0      (pkt_count0),
        .pkt_count1      (pkt_count1),
        .abort_count     (abort_count)
    );

    int errors = 0;
    int checks = 0;

    beat_t       txq [2][$];
    logic [71:0] expq [2][$];
    int          plen [2][$];
    int          order_q [$];
    int          exp_pkt [2];
    int          exp_abort;
    int          bld_n [2];
    int          bld_fwd [2];
    bit          bld_ab [2];

    bit   gaps = 0;
    bit   wiggle = 0;
    bit   mr_rand = 0;
    logic mr_force = 1'b1;
    bit   acc [2];
    int   fwd_n = 0;
    int   pr_n = 0;
    int   hold_n = 0;

    task automatic check(input string tag, input logic [79:0] obs,
                         input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level model: what a payload should produce on the output.
    task automatic add_beat(input int s, input logic [63:0] b,
                            input logic [7:0] e, input logic l);
        beat_t x;
        x.bytes = b;
        x.enables = e;
        x.last = l;
        bld_n[s]++;
        if (!bld_ab[s]) begin
            if (bld_n[s] == MAXB + 1 && !l) bld_ab[s] = 1;
            else if (e != 8'd0) begin
                expq[s].push_back({b, e});
                bld_fwd[s]++;
            end
        end
        if (l) begin
            if (bld_fwd[s] != 0) plen[s].push_back(bld_fwd[s]);
            if (bld_ab[s]) exp_abort++;
            else exp_pkt[s]++;
            bld_n[s] = 0;
            bld_fwd[s] = 0;
            bld_ab[s] = 0;
        end
        txq[s].push_back(x);
    endtask

    function automatic logic [63:0] tag_word(input int s);
        return {(s != 0) ? 8'hB1 : 8'hB0, 24'($urandom), 32'($urandom)};
    endfunction

    task automatic rand_pkt(input int s, input int nmax);
        int n;
        logic [7:0] e;
        n = $urandom_range(nmax, 1);
        for (int i = 0; i < n; i++) begin
            e = ($urandom_range(4) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
            add_beat(s, tag_word(s), e, i == n - 1);
        end
    endtask

    task automatic wait_done(input int bound);
        int c;
        bit done;
        c = 0;
        done = 0;
        while (!done && c < bound) begin
            @(negedge clk);
            c++;
            done = txq[0].size() == 0 && txq[1].size() == 0 &&
                   !sv[0] && !sv[1] &&
                   expq[0].size() == 0 && expq[1].size() == 0 &&
                   !m_data_valid;
        end
        check("drain_done", 80'(done), 80'd1);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_fwd(input int target, input int bound);
        int c;
        c = 0;
        while (fwd_n < target && c < bound) begin
            @(negedge clk);
            c++;
        end
        check("fwd_reach", 80'(fwd_n >= target), 80'd1);
    endtask

    task automatic clear_model();
        for (int s = 0; s < 2; s++) begin
            txq[s].delete();
            expq[s].delete();
            plen[s].delete();
            sv[s] = 1'b0;
            exp_pkt[s] = 0;
            bld_n[s] = 0;
            bld_fwd[s] = 0;
            bld_ab[s] = 0;
        end
        exp_abort = 0;
    endtask

    for (genvar g = 0; g < 2; g++) begin : drv
        initial begin
            beat_t b;
            bit skip;
            sv[g] = 1'b0;
            sb[g] = '0;
            se[g] = '0;
            sl[g] = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                skip = 0;
                if (sv[g]) begin
                    if (acc[g]) begin
                        sv[g] = 1'b0;
                    end else if (wiggle && $urandom_range(7) == 0) begin
                        sv[g] = 1'b0;
                        txq[g].push_front(b);
                        skip = 1;
                    end
                end
                if (!skip && !sv[g] && txq[g].size() != 0 &&
                    (!gaps || $urandom_range(2) != 0)) begin
                    b = txq[g].pop_front();
                    sb[g] = b.bytes;
                    se[g] = b.enables;
                    sl[g] = b.last;
                    sv[g] = 1'b1;
                end
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = mr_rand ? ($urandom_range(3) != 0) : mr_force;
        end
    end

    initial begin
        int cur, rem, s;
        bit prev_hold, prev_last;
        logic [72:0] hold_val;
        logic [71:0] obs, expv;
        cur = 0;
        rem = 0;
        prev_hold = 0;
        prev_last = 0;
        hold_val = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rem = 0;
                prev_hold = 0;
                prev_last = 0;
                acc[0] = 0;
                acc[1] = 0;
            end else begin
                if (parser_reset) pr_n++;
                check("one_ready", 80'(s0_ready & s1_ready), 80'd0);
                acc[0] = sv[0] && s0_ready;
                acc[1] = sv[1] && s1_ready;
                if (acc[0] || acc[1]) check("idle_gap", 80'(prev_last), 80'd0);
                prev_last = (acc[0] && sl[0]) || (acc[1] && sl[1]);
                if (prev_hold) begin
                    hold_n++;
                    check("hold", 80'({m_data_valid, m_bytes, m_byte_enables}),
                          80'(hold_val));
                end
                if (m_data_valid && m_ready) begin
                    obs = {m_bytes, m_byte_enables};
                    if (rem == 0) begin
                        s = (expq[1].size() != 0 && expq[1][0] == obs) ? 1 : 0;
                        cur = s;
                        rem = (plen[s].size() != 0) ? plen[s].pop_front() : 1;
                        order_q.push_back(s);
                    end
                    if (expq[cur].size() != 0) expv = expq[cur].pop_front();
                    else expv = 'x;
                    check("beat", 80'(obs), 80'(expv));
                    rem--;
                    fwd_n++;
                end
                prev_hold = m_data_valid && !m_ready;
                hold_val = {1'b1, m_bytes, m_byte_enables};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, pat, base, hb, pb;
        reset = 1'b1;
        clear_model();
        rand_pkt(1, 3);
        repeat (3) @(negedge clk);
        check("rst_mvalid", 80'(m_data_valid), 80'd0);
        check("rst_mbytes", 80'(m_bytes), 80'd0);
        check("rst_men", 80'(m_byte_enables), 80'd0);
        check("rst_ready", 80'({s0_ready, s1_ready}), 80'd0);
        check("rst_preset", 80'(parser_reset), 80'd0);
        check("rst_cnt", 80'({pkt_count0, pkt_count1, abort_count}), 80'd0);

        @(posedge clk);
        #2 reset = 1'b0;
        npulse = 0;
        pat = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (parser_reset) begin
                npulse++;
                if (pat < 0) pat = c;
            end
            if (pat >= 0 && c <= pat + HOLD)
                check("hold_quiet", 80'({s0_ready, s1_ready, m_data_valid}), 80'd0);
        end
        check("pulse_cnt", 80'(npulse), 80'd1);
        wait_done(200);
        check("first_pkt1", 80'(pkt_count1), 80'(exp_pkt[1]));

        for (int r = 0; r < 2; r++) begin
            order_q.delete();
            @(negedge clk);
            for (int k = 0; k < 3; k++) add_beat(0, tag_word(0), 8'hFF, k == 2);
            for (int k = 0; k < 3; k++) add_beat(1, tag_word(1), 8'hFF, k == 2);
            wait_done(200);
            check("cont_n", 80'(order_q.size()), 80'd2);
            if (order_q.size() == 2) begin
                check("cont_first", 80'(order_q[0]), 80'd0);
                check("cont_second", 80'(order_q[1]), 80'd1);
            end
        end
        check("cont_pkt0", 80'(pkt_count0), 80'(exp_pkt[0]));
        check("cont_pkt1", 80'(pkt_count1), 80'(exp_pkt[1]));

        base = fwd_n;
        add_beat(0, 64'h0e00010102000000, 8'hFF, 1'b0);
        add_beat(0, 64'h062019d206000000, 8'hFC, 1'b1);
        wait_done(200);
        check("single_fwd", 80'(fwd_n - base), 80'd2);
        check("single_pkt0", 80'(pkt_count0), 80'(exp_pkt[0]));

        base = fwd_n;
        hb = hold_n;
        for (int k = 0; k < 6; k++) add_beat(0, tag_word(0), 8'hFF, k == 5);
        wait_fwd(base + 2, 100);
        mr_force = 1'b0;
        repeat (5) @(posedge clk);
        mr_force = 1'b1;
        wait_done(200);
        check("bp_fwd", 80'(fwd_n - base), 80'd6);
        check("bp_held", 80'(hold_n - hb >= 3), 80'd1);
        check("bp_pkt0", 80'(pkt_count0), 80'(exp_pkt[0]));

        base = fwd_n;
        add_beat(0, tag_word(0), 8'hFF, 1'b0);
        add_beat(0, tag_word(0), 8'h00, 1'b0);
        add_beat(0, tag_word(0), 8'h0F, 1'b1);
        add_beat(0, tag_word(0), 8'hFF, 1'b0);
        add_beat(0, tag_word(0), 8'h00, 1'b1);
        wait_done(200);
        check("zero_fwd", 80'(fwd_n - base), 80'd3);
        check("zero_pkt0", 80'(pkt_count0), 80'(exp_pkt[0]));

        base = fwd_n;
        pb = pr_n;
        mr_rand = 1;
        for (int k = 0; k < 200; k++)
            add_beat(1, tag_word(1), 8'($urandom_range(255, 1)), k == 199);
        wait_done(3000);
        mr_rand = 0;
        check("abort_fwd", 80'(fwd_n - base), 80'(MAXB));
        check("abort_cnt", 80'(abort_count), 80'(exp_abort));
        check("abort_pkt1", 80'(pkt_count1), 80'(exp_pkt[1]));
        check("abort_pulse", 80'(pr_n - pb), 80'd1);

        base = fwd_n;
        for (int k = 0; k < 10; k++) add_beat(0, tag_word(0), 8'hFF, k == 9);
        wait_fwd(base + 3, 100);
        @(posedge clk);
        #2;
        reset = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        check("mid_cnt", 80'({pkt_count0, pkt_count1, abort_count}), 80'd0);
        check("mid_mvalid", 80'(m_data_valid), 80'd0);
        @(posedge clk);
        #2 reset = 1'b0;
        add_beat(0, tag_word(0), 8'hFF, 1'b0);
        add_beat(0, tag_word(0), 8'h3C, 1'b1);
        wait_done(200);
        check("mid_pkt0", 80'(pkt_count0), 80'(exp_pkt[0]));

        gaps = 1;
        wiggle = 1;
        mr_rand = 1;
        for (int i = 0; i < 40; i++) begin
            rand_pkt(0, 6);
            rand_pkt(1, 6);
        end
        wait_done(20000);
        check("rand_pkt0", 80'(pkt_count0), 80'(exp_pkt[0]));
        check("rand_pkt1", 80'(pkt_count1), 80'(exp_pkt[1]));
        check("rand_abort", 80'(abort_count), 80'(exp_abort));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
